// File: rtl/event_capture_pkg.sv
// event_capture_pkg
//   Shared constants and helpers for the event-capture block.
//   - OVF_W            : width of the saturating drop counter
//   - MAX_WIDTH        : largest supported event vector width
//   - rec_width()      : packed record width {ts, value, changed}
//   - snapshot_changed(): all-ones "changed" mask used by the post-reset snapshot
package event_capture_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int OVF_W     = 16;

  // Record layout in FIFO storage, MSB first: ts, value, changed.
  function automatic int rec_width(input int ts_w, input int ev_w);
    return ts_w + 2 * ev_w;
  endfunction

  // Ones in the low ev_w bits; the caller keeps the bits it needs.
  function automatic logic [MAX_WIDTH-1:0] snapshot_changed(input int ev_w);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < ev_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/event_capture_if.sv
// event_capture_if
//   Bundles the event inputs, masks and the record output stream of
//   event_capture.
//   master : event source / record consumer (drives ev, enable, masks, out_ready)
//   slave  : the capture block (drives out_* stream, count, overflow_cnt)
interface event_capture_if
  import event_capture_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 32
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    ev;
  logic                enable;
  logic [WIDTH-1:0]    rise_en;
  logic [WIDTH-1:0]    fall_en;
  logic                out_valid;
  logic                out_ready;
  logic [TS_WIDTH-1:0] out_ts;
  logic [WIDTH-1:0]    out_value;
  logic [WIDTH-1:0]    out_changed;
  logic [CNT_W-1:0]    count;
  logic [OVF_W-1:0]    overflow_cnt;

  modport master (
    output ev, enable, rise_en, fall_en, out_ready,
    input  out_valid, out_ts, out_value, out_changed, count, overflow_cnt
  );

  modport slave (
    input  ev, enable, rise_en, fall_en, out_ready,
    output out_valid, out_ts, out_value, out_changed, count, overflow_cnt
  );

endinterface

// File: rtl/event_capture_fifo.sv
// event_capture_fifo
//   Generic synchronous show-ahead FIFO, DEPTH a power of two >= 2.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset (pointers only)
//     push_i     : write din_i; accepted when not full, or when full and
//                  a pop happens in the same cycle
//     pop_i      : remove head; ignored when empty
//     din_i      : write data
//     dout_o     : head entry, combinational from storage
//     full_o     : DEPTH entries held
//     empty_o    : no entries held
//     count_o    : occupancy 0..DEPTH
module event_capture_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      din_i,
  output logic [DATA_W-1:0]      dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop_i && !empty_o;
    // A pop frees the slot a same-cycle push needs when full.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    count_o  = wr_ptr_q - rd_ptr_q;
    dout_o   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is data only; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/event_capture.sv
// event_capture
//   Samples an event vector every clock, detects masked per-bit rising and
//   falling edges, and queues a timestamped record {ts, value, changed} per
//   detected change in a DEPTH-entry FIFO drained over a valid/ready stream.
//   The first cycle after reset pushes a snapshot of ev (changed = all ones)
//   when enable is high in that cycle.
//   Ports:
//     clk  : clock, posedge
//     rst  : synchronous active-high reset
//     bus  : event_capture_if.slave
//            ev, enable, rise_en, fall_en     - capture inputs
//            out_valid/out_ready, out_ts,
//            out_value, out_changed           - show-ahead record stream
//            count                            - FIFO occupancy
//            overflow_cnt                     - dropped records, saturating
module event_capture
  import event_capture_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  event_capture_if.slave bus
);

  localparam int REC_W = rec_width(TS_WIDTH, WIDTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [MAX_WIDTH-1:0] SNAP_FULL = snapshot_changed(WIDTH);
  localparam logic [WIDTH-1:0] SNAPSHOT_CHANGED = SNAP_FULL[WIDTH-1:0];

  function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
    return (v == {OVF_W{1'b1}}) ? v : v + {{(OVF_W-1){1'b0}}, 1'b1};
  endfunction

  logic [WIDTH-1:0]    ev_q, ev_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                first_q;
  logic [OVF_W-1:0]    ovf_q, ovf_d;

  logic [WIDTH-1:0]    trig;
  logic [WIDTH-1:0]    changed;
  logic                push_req;
  logic                pop;
  logic                drop;
  logic [REC_W-1:0]    rec_in;
  logic [REC_W-1:0]    rec_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;

  always_comb begin
    trig     = (bus.ev & ~ev_q & bus.rise_en) | (~bus.ev & ev_q & bus.fall_en);
    // first_q is high only in the cycle right after reset; if enable is low
    // then, the snapshot is lost rather than carried forward.
    push_req = bus.enable && (first_q || (|trig));
    changed  = first_q ? SNAPSHOT_CHANGED : trig;
    rec_in   = {ts_q, bus.ev, changed};
    pop      = !fifo_empty && bus.out_ready;
    drop     = push_req && fifo_full && !pop;
    ovf_d    = drop ? sat_inc(ovf_q) : ovf_q;
    ts_d     = ts_q + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    ev_d     = bus.ev;
  end

  // Capture stage: previous ev, timestamp, snapshot flag, drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_q    <= '0;
      ts_q    <= '0;
      first_q <= 1'b1;
      ovf_q   <= '0;
    end else begin
      ev_q    <= ev_d;
      ts_q    <= ts_d;
      first_q <= 1'b0;
      ovf_q   <= ovf_d;
    end
  end

  event_capture_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .pop_i   (pop),
    .din_i   (rec_in),
    .dout_o  (rec_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_ts      = rec_head[REC_W-1 -: TS_WIDTH];
  assign bus.out_value   = rec_head[2*WIDTH-1 -: WIDTH];
  assign bus.out_changed = rec_head[WIDTH-1:0];
  assign bus.count        = fifo_count;
  assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_event_capture.sv
module tb_event_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  event_capture_if #(.WIDTH(32), .DEPTH(8), .TS_WIDTH(32)) a_if ();
  event_capture_if #(.WIDTH(8),  .DEPTH(4), .TS_WIDTH(4))  b_if ();

  event_capture #(.WIDTH(32), .DEPTH(8), .TS_WIDTH(32)) dut_a (
    .clk (clk), .rst (rst_a), .bus (a_if)
  );
  event_capture #(.WIDTH(8), .DEPTH(4), .TS_WIDTH(4)) dut_b (
    .clk (clk), .rst (rst_b), .bus (b_if)
  );

  typedef struct {
    logic        en;
    logic [31:0] ev;
    logic [31:0] rise;
    logic [31:0] fall;
    logic        rdy;
    logic        push;   // a record is expected to be requested this cycle
    logic [31:0] chg;    // expected changed field of that record
    int          cnt;    // expected count after the edge
    int          ovf;    // expected overflow_cnt after the edge
  } vec_t;

  typedef struct {
    logic [31:0] ts;
    logic [31:0] value;
    logic [31:0] changed;
  } rec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   step_no = 0;
  int   tsm_a = 0;
  int   tsm_b = 0;
  rec_t sb_a[$];
  rec_t sb_b[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [31:0] ev,
                              input logic [31:0] rise, input logic [31:0] fall,
                              input logic rdy, input logic push,
                              input logic [31:0] chg, input int cnt, input int ovf);
    vec_t v;
    v.en = en; v.ev = ev; v.rise = rise; v.fall = fall; v.rdy = rdy;
    v.push = push; v.chg = chg; v.cnt = cnt; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %0h, want %0h", name, step_no, act, exp);
  endtask

  task automatic drive(input int sel, input vec_t v);
    if (sel == 0) begin
      a_if.enable = v.en; a_if.ev = v.ev; a_if.rise_en = v.rise;
      a_if.fall_en = v.fall; a_if.out_ready = v.rdy;
    end else begin
      b_if.enable = v.en; b_if.ev = v.ev[7:0]; b_if.rise_en = v.rise[7:0];
      b_if.fall_en = v.fall[7:0]; b_if.out_ready = v.rdy;
    end
  endtask

  task automatic sample(input int sel, output logic vld, output logic [31:0] ts,
                        output logic [31:0] val, output logic [31:0] chg,
                        output int cnt, output int ovf);
    if (sel == 0) begin
      vld = a_if.out_valid; ts = a_if.out_ts; val = a_if.out_value;
      chg = a_if.out_changed; cnt = int'(a_if.count); ovf = int'(a_if.overflow_cnt);
    end else begin
      vld = b_if.out_valid; ts = 32'(b_if.out_ts); val = 32'(b_if.out_value);
      chg = 32'(b_if.out_changed); cnt = int'(b_if.count); ovf = int'(b_if.overflow_cnt);
    end
  endtask

  // Called 1 time unit after a posedge. Drives, checks the head before the
  // next edge, updates the scoreboard, then checks count/overflow after it.
  task automatic step(input int sel, input vec_t v);
    logic        vld;
    logic [31:0] ts, val, chg;
    int          cnt, ovf, size, depth;
    rec_t        e;
    drive(sel, v);
    #2;
    sample(sel, vld, ts, val, chg, cnt, ovf);
    size  = (sel == 0) ? sb_a.size() : sb_b.size();
    depth = (sel == 0) ? 8 : 4;
    chk("out_valid", 32'(vld), 32'(size != 0));
    if (vld && v.rdy && size != 0) begin
      if (sel == 0) e = sb_a.pop_front(); else e = sb_b.pop_front();
      chk("out_ts", ts, e.ts);
      chk("out_value", val, e.value);
      chk("out_changed", chg, e.changed);
      size--;
    end
    if (v.push && size < depth) begin
      e.ts      = (sel == 0) ? 32'(tsm_a) : 32'(tsm_b % 16);
      e.value   = v.ev;
      e.changed = v.chg;
      if (sel == 0) sb_a.push_back(e); else sb_b.push_back(e);
    end
    @(posedge clk); #1;
    if (sel == 0) tsm_a++; else tsm_b++;
    sample(sel, vld, ts, val, chg, cnt, ovf);
    chk("count", 32'(cnt), 32'(v.cnt));
    chk("overflow_cnt", 32'(ovf), 32'(v.ovf));
    step_no++;
  endtask

  task automatic do_reset(input int sel);
    logic        vld;
    logic [31:0] ts, val, chg;
    int          cnt, ovf;
    drive(sel, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    @(posedge clk); #1;
    sample(sel, vld, ts, val, chg, cnt, ovf);
    chk("reset out_valid", 32'(vld), 32'd0);
    chk("reset count", 32'(cnt), 32'd0);
    chk("reset overflow_cnt", 32'(ovf), 32'd0);
    if (sel == 0) begin rst_a = 1'b0; sb_a.delete(); tsm_a = 0; end
    else          begin rst_b = 1'b0; sb_b.delete(); tsm_b = 0; end
  endtask

  initial begin
    logic [31:0] prev, cur, ones;
    ones = 32'hFFFF_FFFF;
    drive(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Snapshot, then pop it.
    tbl.push_back(mk(1, 32'h5, 0, 0, 0, 1, ones, 1, 0));
    tbl.push_back(mk(1, 32'h5, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h5, 0, 0, 1, 0, 0, 0, 0));
    // Rise-only on bit0: fall ignored, rise recorded at ts 4.
    tbl.push_back(mk(1, 32'h4, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h5, 1, 0, 1, 1, 32'h1, 1, 0));
    tbl.push_back(mk(1, 32'h4, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h4, 1, 0, 1, 0, 0, 0, 0));
    // Ten triggers with no consumer: 8 stored, 2 dropped.
    prev = 32'h4;
    for (int i = 0; i < 10; i++) begin
      cur = 32'h100 + 32'(i);
      tbl.push_back(mk(1, cur, ones, ones, 0, 1, cur ^ prev,
                       (i < 8) ? i + 1 : 8, (i < 8) ? 0 : i - 7));
      prev = cur;
    end
    // Full with pop and push together: nothing dropped.
    tbl.push_back(mk(1, 32'h200, ones, ones, 1, 1, 32'h309, 8, 2));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 32'h200, ones, ones, 1, 0, 0, 7 - k, 2));
    // Disabled while toggling, then steady on re-enable: nothing queued.
    tbl.push_back(mk(0, 32'h1, ones, ones, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 32'h2, ones, ones, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 32'h3, ones, ones, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h3, ones, ones, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h3, ones, ones, 1, 0, 0, 0, 2));
    // Masks applied in the same cycle as the edge.
    tbl.push_back(mk(1, 32'h7, 32'h4, 0, 1, 1, 32'h4, 1, 2));
    tbl.push_back(mk(1, 32'h5, 0, 32'h2, 1, 1, 32'h2, 1, 2));
    tbl.push_back(mk(1, 32'h5, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h5, 0, 0, 1, 0, 0, 0, 2));

    do_reset(0);
    for (int i = 0; i < tbl.size(); i++) step(0, tbl[i]);

    // TS_WIDTH=4 instance: timestamp wrap across triggers at cycles 15 and 17.
    do_reset(1);
    step(1, mk(1, 0, 0, 0, 1, 1, 32'hFF, 1, 0));
    for (int c = 1; c < 15; c++) step(1, mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    step(1, mk(1, 1, 1, 0, 1, 1, 1, 1, 0));
    step(1, mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
    step(1, mk(1, 1, 1, 0, 1, 1, 1, 1, 0));
    step(1, mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
    // Build a backlog, then reset in the middle of it.
    step(1, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    step(1, mk(1, 1, 1, 0, 0, 1, 1, 1, 0));
    step(1, mk(1, 0, 1, 0, 0, 0, 0, 1, 0));
    step(1, mk(1, 1, 1, 0, 0, 1, 1, 2, 0));
    do_reset(1);
    step(1, mk(1, 32'h5A, 0, 0, 0, 1, 32'hFF, 1, 0));
    step(1, mk(1, 32'h5A, 0, 0, 1, 0, 0, 0, 0));
    // Snapshot skipped when enable is low in the first cycle, not deferred.
    do_reset(1);
    step(1, mk(0, 32'h33, 32'hFF, 32'hFF, 1, 0, 0, 0, 0));
    step(1, mk(1, 32'h33, 32'hFF, 32'hFF, 1, 0, 0, 0, 0));
    step(1, mk(1, 32'h33, 32'hFF, 32'hFF, 1, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/event_capture.md
# event_capture

Parametrised event-capture block for DV BFMs. It samples a WIDTH-bit event vector every clock and detects per-bit rising and/or falling edges under runtime masks. Each detected change becomes a timestamped record in a DEPTH-entry FIFO, drained through a valid/ready stream. It replaces the single-channel, unbuffered change notifier: the BFM proxy now drains records at its own pace, and loss is counted rather than silent.

## Interface
- WIDTH, 32: event vector width, 1..64
- DEPTH, 8: FIFO entries; power of two, ≥2
- TS_WIDTH, 32: timestamp counter width
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- ev  in  WIDTH  event vector, synchronous to clk
- enable  in  1  capture enable; 0 suppresses pushes only
- rise_en  in  WIDTH  per-bit rising-edge detect mask
- fall_en  in  WIDTH  per-bit falling-edge detect mask
- out_valid  out  1  head record valid
- out_ready  in  1  consumer accepts head record
- out_ts  out  TS_WIDTH  timestamp of head record
- out_value  out  WIDTH  ev value captured in head record
- out_changed  out  WIDTH  bits that triggered the record (all ones for the snapshot)
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow_cnt  out  16  dropped records, saturating at 16'hFFFF

## Operation
- ev_r: registered copy of ev, updated every non-reset cycle, including while enable=0.
- trig = (ev & ~ev_r & rise_en) | (~ev & ev_r & fall_en); push request when enable && |trig.
- Snapshot: the first cycle after rst deasserts pushes ev with out_changed = all ones, regardless of masks, if enable=1 in that cycle. If enable=0 in that cycle, the snapshot is skipped, not deferred.
- ts: free-running counter. It is 0 in the first cycle after reset and increments every cycle. It wraps modulo 2^TS_WIDTH. A record carries the ts value of its capture cycle.
- FIFO: circular buffer, read/write pointers with an extra wrap bit. Pop occurs when out_valid && out_ready.
- Full with a push request and no pop: record dropped, overflow_cnt increments. Records already in the FIFO are untouched.
- Full with push and pop in the same cycle: both happen; nothing is dropped and count is unchanged.
- Empty with push and out_ready=1: the push is stored. The pop does not happen because out_valid was 0.
- Mask changes take effect in the cycle they are applied. Masks are not registered.

## Timing
- Reset values: out_valid=0, count=0, overflow_cnt=0, ts=0, ev_r=0. The FIFO is logically empty; out_ts, out_value and out_changed are don't-care while out_valid=0.
- Capture latency: ev changes before posedge N and is sampled at N. The record is written at N, and out_valid is high in the cycle after N when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- Outputs are show-ahead: out_ts, out_value and out_changed reflect the head entry combinationally from the FIFO storage and are stable while out_valid && !out_ready.
- rst asserted mid-operation: at the next edge, all records are discarded, counters clear, and a new snapshot follows deassertion.
- overflow_cnt holds at 16'hFFFF with no wrap.

## Structure
- event_capture_pkg: record typedef (ts, value, changed) as a parameterised struct or width-derived localparams, plus a SNAPSHOT_CHANGED all-ones constant helper.
- One sub-module, event_capture_fifo: generic synchronous FIFO with push, pop, full, empty and count. Edge detection, ts and overflow logic stay in event_capture.
- The BFM interface wrapper (DPI or virtual-interface proxy) instantiates event_capture and drives out_ready. It is outside this block.

## Test plan
- Reset, then enable=1, ev=32'h5 with masks 0 → one record {ts=0, value=5, changed=FFFFFFFF}, then out_valid=0.
- rise_en=1, fall_en=0; ev bit0 pulses 0→1→0 → exactly one record, changed=1, ts = cycle of the rise.
- DEPTH=8, out_ready=0, 10 distinct triggers → count=8, overflow_cnt=2; drained records are the first 8 in order.
- Full FIFO, out_ready=1 with a trigger in the same cycle → count stays 8, overflow_cnt unchanged.
- enable=0 while ev toggles, then enable=1 with ev steady → no records, and no stale record on re-enable.
- TS_WIDTH=4, triggers at cycles 15 and 17 → ts 15 then 1 (wrap); reset mid-burst → count=0 and a new snapshot with ts=0.
